// File: rtl/ping_pong_ctrl_if.sv
// Producer/consumer stream bundle for ping_pong_ctrl.
// PP_CTRL_LAST_EN adds the in_last/out_last framing bits.
interface ping_pong_ctrl_if #(
  parameter int BIT_LENGTH = 64
);
  // valid/ready: a beat moves on a rising clk edge where valid and ready are both
  // high; the sender holds valid and its payload steady until that beat happens.
  logic                  in_valid;
  logic                  in_ready;
  logic [BIT_LENGTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIT_LENGTH-1:0] out_data;
`ifdef PP_CTRL_LAST_EN
  logic                  in_last;
  logic                  out_last;
`endif

  modport slave (
`ifdef PP_CTRL_LAST_EN
    input  in_last,
    output out_last,
`endif
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport master (
`ifdef PP_CTRL_LAST_EN
    output in_last,
    input  out_last,
`endif
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/ping_pong_ctrl.sv
// Double-buffer controller: fills one bank of an external dual-port RAM while the other
// drains through a 2-entry output FIFO. PP_CTRL_LAST_EN enables early bank close via in_last.
module ping_pong_ctrl #(
  parameter int BIT_LENGTH = 64,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ping_pong_ctrl_if.slave          stream,
  output logic                     ena,
  output logic                     wea,
  output logic [$clog2(DEPTH)-1:0] addra,
  output logic [BIT_LENGTH-1:0]    dina,
  output logic                     enb,
  output logic [$clog2(DEPTH)-1:0] addrb,
  input  logic [BIT_LENGTH-1:0]    doutb,
  output logic                     ping_pong,
  output logic                     swap,
  output logic                     wr_state_dbg,
  output logic                     rd_state_dbg
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] WR_FILL  = 1'b0;
  localparam logic [0:0] WR_FULL  = 1'b1;
  localparam logic [0:0] RD_IDLE  = 1'b0;
  localparam logic [0:0] RD_DRAIN = 1'b1;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [0:0]            wr_state;
  logic [0:0]            rd_state;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         bank_last;
  logic [AW-1:0]         rd_last;
  logic                  in_flight;
  logic [BIT_LENGTH-1:0] fifo_data [2];
  logic                  fifo_wr;
  logic                  fifo_rd;
  logic [1:0]            fifo_cnt;
  logic [1:0]            fifo_level;
  logic                  transfer;
  logic                  close_bank;
  logic                  pop;
  logic                  issue;
  logic [BIT_LENGTH-1:0] head;

  // Reset gating keeps in_ready low while rst_n is asserted even though the state is FILL.
  assign stream.in_ready = rst_n && (wr_state == WR_FILL);
  assign transfer        = stream.in_valid && stream.in_ready;

`ifdef PP_CTRL_LAST_EN
  assign close_bank = transfer && ((wr_ptr == LAST_IDX) || stream.in_last);
`else
  assign close_bank = transfer && (wr_ptr == LAST_IDX);
`endif

  assign swap = (wr_state == WR_FULL) && (rd_state == RD_IDLE) && !in_flight;

  // A word returning from the RAM is visible at once when the FIFO is empty, so the
  // first output appears two cycles after the swap instead of three.
  assign stream.out_valid = (fifo_cnt != 2'd0) || in_flight;
  assign pop              = stream.out_valid && stream.out_ready;
  assign head             = (fifo_cnt == 2'd0) ? doutb : fifo_data[fifo_rd];
  assign stream.out_data  = stream.out_valid ? head : '0;

  // Occupancy once this cycle's returning word and pop settle; issue only if room remains.
  assign fifo_level = fifo_cnt + {1'b0, in_flight} - {1'b0, pop};
  assign issue      = (rd_state == RD_DRAIN) && (fifo_level < 2'd2);

  assign ena          = transfer;
  assign wea          = transfer;
  assign addra        = wr_ptr;
  assign dina         = transfer ? stream.in_data : '0;
  assign enb          = issue;
  assign addrb        = rd_ptr;
  assign wr_state_dbg = wr_state;
  assign rd_state_dbg = rd_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state  <= WR_FILL;
      wr_ptr    <= '0;
      bank_last <= '0;
    end else begin
      if (transfer) wr_ptr <= close_bank ? '0 : wr_ptr + AW'(1);
      if (close_bank) begin
        wr_state  <= WR_FULL;
        bank_last <= wr_ptr;
      end else if (swap) begin
        wr_state <= WR_FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state  <= RD_IDLE;
      rd_ptr    <= '0;
      rd_last   <= '0;
      ping_pong <= 1'b0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= issue;
      if (swap) begin
        rd_state  <= RD_DRAIN;
        rd_ptr    <= '0;
        rd_last   <= bank_last;
        ping_pong <= ~ping_pong;
      end else if (issue) begin
        rd_ptr <= rd_ptr + AW'(1);
        if (rd_ptr == rd_last) rd_state <= RD_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr  <= 1'b0;
      fifo_rd  <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (in_flight) fifo_wr <= ~fifo_wr;
      if (pop)       fifo_rd <= ~fifo_rd;
      fifo_cnt <= fifo_level;
    end
  end

  always_ff @(posedge clk) begin
    if (in_flight) fifo_data[fifo_wr] <= doutb;
  end

`ifdef PP_CTRL_LAST_EN
  logic bank_tag;
  logic rd_tag;
  logic flight_last;
  logic fifo_last [2];

  // Only a bank closed by in_last marks its final word with out_last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_tag    <= 1'b0;
      rd_tag      <= 1'b0;
      flight_last <= 1'b0;
    end else begin
      if (close_bank) bank_tag <= stream.in_last;
      if (swap)       rd_tag   <= bank_tag;
      flight_last <= issue && rd_tag && (rd_ptr == rd_last);
    end
  end

  always_ff @(posedge clk) begin
    if (in_flight) fifo_last[fifo_wr] <= flight_last;
  end

  assign stream.out_last = stream.out_valid &&
                           ((fifo_cnt == 2'd0) ? flight_last : fifo_last[fifo_rd]);
`endif
endmodule

// File: tb/tb_ping_pong_ctrl.sv
// Bench for ping_pong_ctrl (DEPTH=4, BIT_LENGTH=8): directed bank scenarios plus random
// valid/ready traffic scored against an in-order expected queue.
module tb_ping_pong_ctrl;
  localparam int BL    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ping_pong_ctrl_if #(.BIT_LENGTH(BL)) bus ();

  logic          ena, wea, enb, ping_pong, swap, wr_state_dbg, rd_state_dbg;
  logic [AW-1:0] addra, addrb;
  logic [BL-1:0] dina, doutb;

  ping_pong_ctrl #(.BIT_LENGTH(BL), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stream       (bus),
    .ena          (ena),
    .wea          (wea),
    .addra        (addra),
    .dina         (dina),
    .enb          (enb),
    .addrb        (addrb),
    .doutb        (doutb),
    .ping_pong    (ping_pong),
    .swap         (swap),
    .wr_state_dbg (wr_state_dbg),
    .rd_state_dbg (rd_state_dbg)
  );

  // Two-bank RAM: writes go to bank ping_pong, reads come from the other bank.
  logic [BL-1:0] mem [2][DEPTH];
  always @(posedge clk) begin
    if (ena && wea) mem[ping_pong][addra] <= dina;
    if (enb) doutb <= mem[~ping_pong][addrb];
  end

  int            n_checks = 0;
  int            n_errors = 0;
  logic [BL-1:0] exp_q[$];
  int            n_in, n_out, n_swap;
  logic          xfer, prev_stall;
  logic [BL-1:0] prev_data;
  logic          ir_q[$], sw_q[$], pp_q[$], ov_q[$], en_q[$], pop_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int first_val(input logic q[$], input logic v);
    for (int i = 0; i < q.size(); i++) if (q[i] == v) return i;
    return -1;
  endfunction

  function automatic int last_val(input logic q[$], input logic v);
    for (int i = q.size() - 1; i >= 0; i--) if (q[i] == v) return i;
    return -1;
  endfunction

  function automatic int count_val(input logic q[$], input logic v);
    int n = 0;
    for (int i = 0; i < q.size(); i++) if (q[i] == v) n++;
    return n;
  endfunction

  function automatic int toggles(input logic q[$]);
    int n = 0;
    for (int i = 1; i < q.size(); i++) if (q[i] != q[i-1]) n++;
    return n;
  endfunction

  task automatic clear_logs();
    ir_q.delete(); sw_q.delete(); pp_q.delete();
    ov_q.delete(); en_q.delete(); pop_q.delete();
  endtask

  // Called at a negedge with inputs already driven; samples just before the next posedge.
  task automatic tick();
    #1;
    if (prev_stall) begin
      check_eq("hold_valid", bus.out_valid, 1);
      check_eq("hold_data", bus.out_data, prev_data);
    end
    ir_q.push_back(bus.in_ready);
    sw_q.push_back(swap);
    pp_q.push_back(ping_pong);
    ov_q.push_back(bus.out_valid);
    en_q.push_back(enb);
    pop_q.push_back(bus.out_valid && bus.out_ready);
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check_eq("pop_when_empty", exp_q.size(), 1);
      else check_eq("out_order", bus.out_data, exp_q.pop_front());
      n_out++;
    end
    xfer = bus.in_valid && bus.in_ready;
    if (xfer) begin
      exp_q.push_back(bus.in_data);
      n_in++;
    end
    if (swap) n_swap++;
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef PP_CTRL_LAST_EN
    bus.in_last   = 1'b0;
`endif
    rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_in_ready", bus.in_ready, 0);
    check_eq("rst_ena", ena, 0);
    check_eq("rst_wea", wea, 0);
    check_eq("rst_enb", enb, 0);
    check_eq("rst_swap", swap, 0);
    check_eq("rst_ping_pong", ping_pong, 0);
    check_eq("rst_addra", addra, 0);
    check_eq("rst_addrb", addrb, 0);
    check_eq("rst_dina", dina, 0);
    check_eq("rst_out_data", bus.out_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_ready_after", bus.in_ready, 1);
    exp_q.delete();
    n_in = 0; n_out = 0; n_swap = 0;
    xfer = 1'b0; prev_stall = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_seq(input int first, input int count);
    int w;
    int b;
    w = first;
    b = 0;
    while (w < first + count && b < 40) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(w);
      tick();
      if (xfer) w++;
      b++;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic drain_until(input int n, input int budget);
    int b;
    b = 0;
    while (n_out < n && b < budget) begin
      tick();
      b++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got time limit expected self-finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_at_fill, stall_enb, b;

    // One bank, free-running consumer: swap timing and first-word latency.
    do_reset();
    clear_logs();
    bus.out_ready = 1'b1;
    send_seq(1, 4);
    drain_until(4, 30);
    check_eq("a_outputs", n_out, 4);
    check_eq("a_swap_cycle", first_val(sw_q, 1), 4);
    check_eq("a_swap_count", count_val(sw_q, 1), 1);
    check_eq("a_ready_low_cycles", count_val(ir_q, 0), 1);
    check_eq("a_ready_low_at", first_val(ir_q, 0), 4);
    check_eq("a_pp_at_swap", pp_q[4], 0);
    check_eq("a_pp_after_swap", pp_q[5], 1);
    check_eq("a_first_enb", first_val(en_q, 1), 5);
    check_eq("a_first_valid", first_val(ov_q, 1), 6);
    check_eq("a_pop_span", last_val(pop_q, 1) - first_val(pop_q, 1), 3);
    check_eq("a_ready_back", bus.in_ready, 1);
    check_eq("a_wr_fill", wr_state_dbg, 0);
    check_eq("a_rd_idle", rd_state_dbg, 0);

    // Two banks back to back: second bank fills while the first drains.
    do_reset();
    clear_logs();
    bus.out_ready = 1'b1;
    send_seq(1, 8);
    n_at_fill = n_out;
    drain_until(8, 60);
    check_eq("b_in_count", n_in, 8);
    check_eq("b_overlap", n_at_fill < 4, 1);
    check_eq("b_outputs", n_out, 8);
    check_eq("b_swaps", n_swap, 2);
    check_eq("b_pp_toggles", toggles(pp_q), 2);
    check_eq("b_pp_final", ping_pong, 0);

    // Consumer stalled: at most two reads run ahead, head word held.
    do_reset();
    clear_logs();
    bus.out_ready = 1'b0;
    send_seq(1, 4);
    repeat (12) tick();
    stall_enb = count_val(en_q, 1);
    check_eq("c_stall_enb_max2", stall_enb <= 2, 1);
    check_eq("c_valid_held", bus.out_valid, 1);
    check_eq("c_head_word", bus.out_data, 1);
    clear_logs();
    bus.out_ready = 1'b1;
    drain_until(4, 20);
    check_eq("c_outputs", n_out, 4);
    check_eq("c_pop_span", last_val(pop_q, 1) - first_val(pop_q, 1), 3);
    check_eq("c_enb_total", stall_enb + count_val(en_q, 1), 4);

    // Reset mid-drain after two outputs: nothing stale may come out afterwards.
    do_reset();
    clear_logs();
    bus.out_ready = 1'b1;
    send_seq(1, 4);
    drain_until(2, 20);
    check_eq("d_two_out", n_out, 2);
    do_reset();
    clear_logs();
    bus.out_ready = 1'b1;
    repeat (10) tick();
    check_eq("d_no_stale_valid", count_val(ov_q, 1), 0);
    check_eq("d_no_stale_out", n_out, 0);
    check_eq("d_ready", bus.in_ready, 1);

    // Random traffic, then top up to a whole bank and drain.
    do_reset();
    clear_logs();
    for (int i = 0; i < 500; i++) begin
      if (!bus.in_valid || xfer) begin
        bus.in_valid = ($urandom_range(0, 99) < 70);
        bus.in_data  = 8'($urandom_range(0, 255));
      end
      bus.out_ready = ($urandom_range(0, 99) < 60);
      tick();
    end
    b = 0;
    while (b < 200) begin
      if (xfer || !bus.in_valid) begin
        if (n_in % DEPTH == 0) begin
          bus.in_valid = 1'b0;
          break;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom_range(0, 255));
      end
      bus.out_ready = ($urandom_range(0, 99) < 60);
      tick();
      b++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    b = 0;
    while (exp_q.size() > 0 && b < 200) begin
      tick();
      b++;
    end
    check_eq("e_drained", exp_q.size(), 0);
    check_eq("e_out_count", n_out, n_in);
    check_eq("e_swaps", n_swap, n_in / DEPTH);
    check_eq("e_pp_final", ping_pong, (n_in / DEPTH) % 2);

`ifdef PP_CTRL_LAST_EN
    // Early close: two words, in_last on the second.
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'd9;
    bus.in_last   = 1'b0;
    b = 0;
    do begin tick(); b++; end while (!xfer && b < 10);
    bus.in_data = 8'd10;
    bus.in_last = 1'b1;
    do begin tick(); b++; end while (!xfer && b < 20);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid && exp_q.size() != 0)
        check_eq("l_out_last", bus.out_last, exp_q[0] == 8'd10);
      tick();
    end
    check_eq("l_outputs", n_out, 2);
    check_eq("l_swaps", n_swap, 1);
    check_eq("l_rd_idle", rd_state_dbg, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ping_pong_ctrl.md
PING_PONG_CTRL -- requirements
Module: ping_pong_ctrl

Interface
REQ-001 SHALL have parameter BIT_LENGTH, default 64, data word width.
REQ-002 SHALL have parameter DEPTH, default 16, words per bank; power of two, >=2.
REQ-003 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports in_valid in 1, in_ready out 1, in_data in BIT_LENGTH: producer stream.
REQ-006 SHALL have ports out_valid out 1, out_ready in 1, out_data out BIT_LENGTH: consumer stream.
REQ-007 SHALL have buffer write ports ena, wea out 1; addra out clog2(DEPTH); dina out BIT_LENGTH.
REQ-008 SHALL have buffer read ports enb out 1; addrb out clog2(DEPTH); doutb in BIT_LENGTH, valid one cycle after enb.
REQ-009 SHALL have ports ping_pong out 1 (bank select to buffer) and swap out 1 (one-cycle pulse per bank swap).

Function
REQ-010 Write FSM SHALL have states FILL and FULL; read FSM SHALL have states IDLE and DRAIN.
REQ-011 in_ready SHALL equal (write state == FILL); a word transfers when in_valid & in_ready.
REQ-012 On transfer: ena = wea = 1, addra = write pointer, dina = in_data, same cycle; write pointer then increments.
REQ-013 Transfer at pointer DEPTH-1 SHALL move write FSM to FULL next cycle and wrap pointer to 0.
REQ-014 Swap SHALL occur in any cycle where write state == FULL, read state == IDLE and no read in flight.
REQ-015 Swap cycle: swap = 1, ping_pong toggles (registered), write FSM -> FILL, read FSM -> DRAIN, read pointer = 0, read count = bank count.
REQ-016 Read issue: enb = 1, addrb = read pointer, when state == DRAIN and (output FIFO occupancy + in-flight reads - pop this cycle) < 2.
REQ-017 doutb of each issued read SHALL be pushed into a 2-entry output FIFO the following cycle; out_valid = FIFO non-empty, out_data = FIFO head.
REQ-018 Issue of the last word of a bank SHALL return read FSM to IDLE next cycle; FIFO contents keep draining independently.
REQ-019 Latency: swap at cycle T -> first enb at T+1 -> out_valid at T+2; with out_ready=1 one word per cycle.
REQ-020 Word order SHALL be preserved across banks; no word lost or duplicated under any out_ready pattern.
REQ-021 out_valid/out_data SHALL stay stable while out_valid & !out_ready.
REQ-022 Producer SHALL fill the next bank while the consumer drains the current bank (full overlap).

Reset
REQ-023 rst_n low SHALL asynchronously force: write FSM FILL, read FSM IDLE, pointers 0, ping_pong 0, FIFO empty, in-flight cleared.
REQ-024 During reset: out_valid, ena, wea, enb, swap = 0; addra, addrb, dina, out_data = 0; in_ready = 0.
REQ-025 First cycle after rst_n release in_ready SHALL be 1; reset mid-transfer discards all buffered data.

Configuration
REQ-026 Macro PP_CTRL_LAST_EN SHALL, when defined, add ports in_last (in 1) and out_last (out 1).
REQ-027 With PP_CTRL_LAST_EN: transfer with in_last closes the bank early (-> FULL), bank count = words written; out_last = 1 on that bank's last output word.
REQ-028 Without PP_CTRL_LAST_EN: no in_last/out_last ports; every bank holds exactly DEPTH words.

Verification (DEPTH=4, BIT_LENGTH=8)
REQ-029 Write 1,2,3,4 back-to-back, out_ready=1 -> in_ready 0 one cycle, swap pulse, ping_pong 0->1, out_data 1,2,3,4 on consecutive cycles, in_ready back to 1.
REQ-030 Write 8 words 1..8 continuously, out_ready=1 -> second bank fills during drain, outputs 1..8 in order, ping_pong 0->1->0.
REQ-031 Bank full, out_ready=0 for 10 cycles -> at most 2 enb issued, out_valid=1 holding 1; release -> 1,2,3,4 without gaps or duplicates.
REQ-032 rst_n low mid-drain after output 2 -> out_valid=0 immediately, ping_pong=0, in_ready=1 after release, no stale word output.
REQ-033 PP_CTRL_LAST_EN: write 9, 10 with in_last on 10 -> swap, outputs 9, 10 with out_last=1 on 10 only, then IDLE.
